// File: rtl/id_ex_stage_reg_pkg.sv
// Shared core definitions for the ID/EX stage: datapath widths, control-bus
// bit layout and the bubble constants used when the EX slot is emptied.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 12;

    // Control bus bit positions
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_JAL      = 6;
    localparam int CTRL_JALR     = 7;
    localparam int CTRL_ALUOP_LO = 8;
    localparam int CTRL_ALUOP_HI = 10;
    localparam int CTRL_USES_RS  = 11;

    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

    // Full EX-slot register image
    typedef struct packed {
        logic              valid;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [CTRL_W-1:0] ctrl;
    } ex_regs_t;

    // Zero indices mean no forwarding match and no regwrite downstream
    localparam ex_regs_t BUBBLE_REGS = '0;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bus: ID-side operands/control in, EX-side registered fields out.
// master = the ID/control side driving the stage, slave = the stage register.
interface id_ex_stage_reg_if
    import core_pkg::*;
#(
    parameter int XW = XLEN,
    parameter int CW = CTRL_W
);
    logic          i_stall;
    logic          i_flush;
    logic          id_valid;
    logic [XW-1:0] id_pc;
    logic [4:0]    id_rs1;
    logic [4:0]    id_rs2;
    logic [4:0]    id_rd;
    logic [XW-1:0] id_rs1_data;
    logic [XW-1:0] id_rs2_data;
    logic [XW-1:0] id_imm;
    logic [CW-1:0] id_ctrl;
    logic          wb_regwrite;
    logic [4:0]    wb_rd;
    logic [XW-1:0] wb_data;

    logic          ex_valid;
    logic [4:0]    ID_EX_rs1;
    logic [4:0]    ID_EX_rs2;
    logic [4:0]    ex_rd;
    logic [XW-1:0] ex_pc;
    logic [XW-1:0] ex_imm;
    logic [XW-1:0] ex_rs1_data;
    logic [XW-1:0] ex_rs2_data;
    logic [CW-1:0] ex_ctrl;
    logic          o_load_use_stall;

    modport master (
        output i_stall, i_flush, id_valid, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_ctrl,
               wb_regwrite, wb_rd, wb_data,
        input  ex_valid, ID_EX_rs1, ID_EX_rs2, ex_rd, ex_pc, ex_imm,
               ex_rs1_data, ex_rs2_data, ex_ctrl, o_load_use_stall
    );

    modport slave (
        input  i_stall, i_flush, id_valid, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_ctrl,
               wb_regwrite, wb_rd, wb_data,
        output ex_valid, ID_EX_rs1, ID_EX_rs2, ex_rd, ex_pc, ex_imm,
               ex_rs1_data, ex_rs2_data, ex_ctrl, o_load_use_stall
    );
endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Pure combinational load-use hazard equation. Kept standalone so the
// hazard unit can reuse it. A load to x0 never counts as a hazard.
module load_use_detect (
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic       id_uses_rs,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       lu
);
    assign lu = ex_valid & ex_memread & (ex_rd != 5'd0) & id_valid & id_uses_rs
              & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register of the RV32I core. Captures ID operands/control,
// inserts a single bubble on load-use, honours global stall and branch flush.
// Optional: define IDEX_WB_BYPASS_EN to forward the WB write into the captured
// operands (for a read-first register file); otherwise wb_* are ignored.
module id_ex_stage_reg
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    id_ex_stage_reg_if.slave  bus
);
    ex_regs_t ex_q;
    ex_regs_t cap;
    logic     lu;

    load_use_detect u_lud (
        .ex_valid   (ex_q.valid),
        .ex_memread (ex_q.ctrl[CTRL_MEMREAD]),
        .ex_rd      (ex_q.rd),
        .id_valid   (bus.id_valid),
        .id_uses_rs (bus.id_ctrl[CTRL_USES_RS]),
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .lu         (lu)
    );

    // Next EX image on a normal capture; an invalid ID slot captures as a bubble
    always_comb begin
        cap = BUBBLE_REGS;
        if (bus.id_valid) begin
            cap.valid    = 1'b1;
            cap.rs1      = bus.id_rs1;
            cap.rs2      = bus.id_rs2;
            cap.rd       = bus.id_rd;
            cap.pc       = bus.id_pc;
            cap.imm      = bus.id_imm;
            cap.rs1_data = bus.id_rs1_data;
            cap.rs2_data = bus.id_rs2_data;
            cap.ctrl     = bus.id_ctrl;
`ifdef IDEX_WB_BYPASS_EN
            if (bus.wb_regwrite && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs1))
                cap.rs1_data = bus.wb_data;
            if (bus.wb_regwrite && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs2))
                cap.rs2_data = bus.wb_data;
`endif
        end
    end

`ifndef IDEX_WB_BYPASS_EN
    // Write-first register file: the WB port is not consulted here
    logic unused_wb;
    assign unused_wb = ^{bus.wb_regwrite, bus.wb_rd, bus.wb_data};
`endif

    // Stage register: reset > stall(hold) > flush/load-use(bubble) > capture
    always_ff @(posedge clk) begin
        if (!rst_n)
            ex_q <= BUBBLE_REGS;
        else if (bus.i_stall)
            ex_q <= ex_q;
        else if (bus.i_flush || lu)
            ex_q <= BUBBLE_REGS;
        else
            ex_q <= cap;
    end

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ID_EX_rs1   = ex_q.rs1;
    assign bus.ID_EX_rs2   = ex_q.rs2;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_pc       = ex_q.pc;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_rs1_data = ex_q.rs1_data;
    assign bus.ex_rs2_data = ex_q.rs2_data;
    assign bus.ex_ctrl     = ex_q.ctrl;

    // A flushed consumer is killed anyway, so it must not freeze the front end
    assign bus.o_load_use_stall = rst_n & lu & ~bus.i_flush;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios plus a random
// run, all compared against a behavioural model of the EX slot.
module tb_id_ex_stage_reg;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    id_ex_stage_reg_if bus ();

    id_ex_stage_reg dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic            v;
        logic [4:0]      rs1, rs2, rd;
        logic [XLEN-1:0] pc, imm, a, b;
        logic [11:0]     ctrl;
    } st_t;

    st_t m;
    int  checks = 0;
    int  errors = 0;

    localparam logic [11:0] C_RW  = 12'h001;
    localparam logic [11:0] C_LD  = 12'h003; // REGWRITE|MEMREAD
    localparam logic [11:0] C_USE = 12'h801; // USES_RS|REGWRITE

    function automatic st_t observed();
        st_t o;
        o.v = bus.ex_valid; o.rs1 = bus.ID_EX_rs1; o.rs2 = bus.ID_EX_rs2; o.rd = bus.ex_rd;
        o.pc = bus.ex_pc; o.imm = bus.ex_imm; o.a = bus.ex_rs1_data; o.b = bus.ex_rs2_data;
        o.ctrl = bus.ex_ctrl;
        return o;
    endfunction

    // A load in EX whose result the ID instruction needs
    function automatic logic model_hazard();
        return m.v && m.ctrl[1] && (m.rd != 0) && bus.id_valid && bus.id_ctrl[11]
               && ((m.rd == bus.id_rs1) || (m.rd == bus.id_rs2));
    endfunction

    function automatic logic model_stall();
        return rst_n && model_hazard() && !bus.i_flush;
    endfunction

    function automatic st_t model_next();
        st_t n;
        n = '0;
        if (!rst_n) return n;
        if (bus.i_stall) return m;
        if (bus.i_flush || model_hazard() || !bus.id_valid) return n;
        n.v = 1'b1; n.rs1 = bus.id_rs1; n.rs2 = bus.id_rs2; n.rd = bus.id_rd;
        n.pc = bus.id_pc; n.imm = bus.id_imm; n.ctrl = bus.id_ctrl;
        n.a = bus.id_rs1_data; n.b = bus.id_rs2_data;
`ifdef IDEX_WB_BYPASS_EN
        if (bus.wb_regwrite && bus.wb_rd != 0 && bus.wb_rd == bus.id_rs1) n.a = bus.wb_data;
        if (bus.wb_regwrite && bus.wb_rd != 0 && bus.wb_rd == bus.id_rs2) n.b = bus.wb_data;
`endif
        return n;
    endfunction

    task automatic tick();
        st_t n;
        n = model_next();
        @(posedge clk);
        m = n;
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [11:0] ctrl);
        bus.id_valid = v; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_ctrl = ctrl; bus.id_pc = $urandom; bus.id_imm = $urandom;
        bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom;
    endtask

    task automatic rand_id();
        set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom));
        bus.wb_regwrite = 1'($urandom); bus.wb_rd = 5'($urandom_range(0, 7));
        bus.wb_data = $urandom;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.i_stall = 0; bus.i_flush = 0;
        bus.wb_regwrite = 0; bus.wb_rd = 0; bus.wb_data = 0;
        set_id(1'b1, 5'd7, 5'd7, 5'd3, C_USE);
        #1;
        checks++;
        if (bus.o_load_use_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b expected 0", bus.o_load_use_stall);
        end
        tick();
        checks++;
        if (observed() !== st_t'(0)) begin
            errors++; $display("FAIL reset_state: got %h expected 0", observed());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_capture();
        set_id(1'b1, 5'd3, 5'd4, 5'd5, C_RW);
        bus.id_imm = 32'h10; bus.id_pc = 32'h100;
        #1;
        checks++;
        if (bus.o_load_use_stall !== 1'b0) begin
            errors++; $display("FAIL capture_stall: got %b expected 0", bus.o_load_use_stall);
        end
        tick();
        checks++;
        if ({bus.ex_valid, bus.ID_EX_rs1, bus.ID_EX_rs2, bus.ex_rd, bus.ex_imm, bus.ex_ctrl}
            !== {1'b1, 5'd3, 5'd4, 5'd5, 32'h10, C_RW}) begin
            errors++; $display("FAIL capture_fields: got v=%b rs1=%0d rs2=%0d rd=%0d imm=%h ctrl=%h expected v=1 rs1=3 rs2=4 rd=5 imm=10 ctrl=%h",
                bus.ex_valid, bus.ID_EX_rs1, bus.ID_EX_rs2, bus.ex_rd, bus.ex_imm, bus.ex_ctrl, C_RW);
        end
        checks++;
        if (observed() !== m) begin
            errors++; $display("FAIL capture_state: got %h expected %h", observed(), m);
        end
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd1, 5'd2, 5'd7, C_LD);
        tick();
        set_id(1'b1, 5'd7, 5'd2, 5'd8, C_USE);
        #1;
        checks++;
        if (bus.o_load_use_stall !== 1'b1) begin
            errors++; $display("FAIL lu_stall: got %b expected 1", bus.o_load_use_stall);
        end
        tick();
        checks++;
        if ({bus.ex_valid, bus.ID_EX_rs1} !== 6'd0) begin
            errors++; $display("FAIL lu_bubble: got v=%b rs1=%0d expected v=0 rs1=0", bus.ex_valid, bus.ID_EX_rs1);
        end
        checks++;
        if (bus.o_load_use_stall !== 1'b0) begin
            errors++; $display("FAIL lu_release: got %b expected 0", bus.o_load_use_stall);
        end
        tick();
        checks++;
        if ({bus.ex_valid, bus.ID_EX_rs1, bus.ex_rd} !== {1'b1, 5'd7, 5'd8} || observed() !== m) begin
            errors++; $display("FAIL lu_consumer: got %h expected %h", observed(), m);
        end
    endtask

    task automatic test_stall();
        st_t snap;
        set_id(1'b1, 5'd2, 5'd3, 5'd4, C_RW);
        tick();
        snap = m;
        bus.i_stall = 1; bus.i_flush = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            tick();
            checks++;
            if (observed() !== snap) begin
                errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, observed(), snap);
            end
        end
        bus.i_stall = 0;
        tick();
        checks++;
        if (observed() !== st_t'(0)) begin
            errors++; $display("FAIL stall_flush_bubble: got %h expected 0", observed());
        end
        bus.i_flush = 0;
    endtask

    task automatic test_flush_vs_lu();
        set_id(1'b1, 5'd1, 5'd1, 5'd7, C_LD);
        tick();
        set_id(1'b1, 5'd7, 5'd0, 5'd9, C_USE);
        bus.i_flush = 1;
        #1;
        checks++;
        if (bus.o_load_use_stall !== 1'b0) begin
            errors++; $display("FAIL flush_lu_stall: got %b expected 0", bus.o_load_use_stall);
        end
        tick();
        checks++;
        if (observed() !== st_t'(0)) begin
            errors++; $display("FAIL flush_lu_bubble: got %h expected 0", observed());
        end
        bus.i_flush = 0;
    endtask

    task automatic test_x0_reset();
        set_id(1'b1, 5'd1, 5'd1, 5'd0, C_LD);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd6, C_USE);
        #1;
        checks++;
        if (bus.o_load_use_stall !== 1'b0) begin
            errors++; $display("FAIL x0_stall: got %b expected 0", bus.o_load_use_stall);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b1 || observed() !== m) begin
            errors++; $display("FAIL x0_capture: got %h expected %h", observed(), m);
        end
        rst_n = 0;
        rand_id();
        tick();
        checks++;
        if (observed() !== st_t'(0)) begin
            errors++; $display("FAIL midreset_state: got %h expected 0", observed());
        end
        rst_n = 1;
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] want;
`ifdef IDEX_WB_BYPASS_EN
        want = 32'hDEAD;
`else
        want = 32'h0;
`endif
        set_id(1'b1, 5'd1, 5'd9, 5'd2, C_USE);
        bus.id_rs2_data = 0;
        bus.wb_regwrite = 1; bus.wb_rd = 9; bus.wb_data = 32'hDEAD;
        tick();
        checks++;
        if (bus.ex_rs2_data !== want) begin
            errors++; $display("FAIL bypass_rs2: got %h expected %h", bus.ex_rs2_data, want);
        end
        bus.wb_regwrite = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_id();
            rst_n = ($urandom_range(0, 49) != 0);
            bus.i_stall = ($urandom_range(0, 4) == 0);
            bus.i_flush = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 1) == 1) bus.id_ctrl[1] = 1'b1;
            #1;
            checks++;
            if (bus.o_load_use_stall !== model_stall()) begin
                errors++; $display("FAIL rand_stall%0d: got %b expected %b", i, bus.o_load_use_stall, model_stall());
            end
            tick();
            checks++;
            if (observed() !== m) begin
                errors++; $display("FAIL rand_state%0d: got %h expected %h", i, observed(), m);
            end
        end
        rst_n = 1; bus.i_stall = 0; bus.i_flush = 0;
    endtask

    initial begin
        m = '0;
        test_reset();
        test_capture();
        test_load_use();
        test_stall();
        test_flush_vs_lu();
        test_x0_reset();
        test_bypass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage RV32I core.
- Captures decoded operands and control from ID and presents them to EX, including the ID_EX_rs1/ID_EX_rs2 fields the operand-forwarding logic compares against EX/MEM and MEM/WB destinations.
- Detects load-use hazards, inserts bubbles, and honours global stall and branch flush.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 12, width of the packed control bus (field layout in package).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- i_stall  in  1  global stall (I$/D$ miss); freezes the register.
- i_flush  in  1  taken branch/jump resolved in EX; kills the ID instruction.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1, id_rs2, id_rd  in  5  register indices.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_ctrl  in  CTRL_W  packed control: REGWRITE, MEMREAD, MEMWRITE, MEMTOREG, ALUSRC, BRANCH, JAL, JALR, ALUOP[2:0], USES_RS (bit 11 = uses rs1|rs2, refined by index checks below).
- wb_regwrite  in  1  WB write enable (bypass only).
- wb_rd  in  5  WB destination index (bypass only).
- wb_data  in  XLEN  WB write data (bypass only).
- ex_valid  out  1  EX slot holds a real instruction.
- ID_EX_rs1, ID_EX_rs2  out  5  registered source indices to the forwarding logic.
- ex_rd  out  5  registered destination.
- ex_pc, ex_imm, ex_rs1_data, ex_rs2_data  out  XLEN  registered payload.
- ex_ctrl  out  CTRL_W  registered control.
- o_load_use_stall  out  1  hold PC and IF/ID this cycle.

Behaviour:
- Register update and reset:
  - All outputs are registers except o_load_use_stall, which is combinational from registered state and the ID inputs.
  - Reset (rst_n = 0 at a clk edge) clears every register to 0, including ex_valid.
  - o_load_use_stall = 0 while in reset.
- Load-use detect (lu):
  - ex_valid & ex_ctrl.MEMREAD & ex_rd != 0 & id_valid & ctrl.USES_RS & (ex_rd == id_rs1 | ex_rd == id_rs2).
- o_load_use_stall = lu & ~i_flush.
- Per-edge priority:
  1. !rst_n: clear all.
  2. i_stall: hold every register unchanged. i_flush must remain asserted by its producer while stalled, because EX is frozen.
  3. i_flush: bubble.
  4. lu: bubble. ID is held upstream and re-presented next cycle, so latency is exactly 1 bubble per load-use.
  5. Otherwise: capture all id_* fields, with ex_valid = id_valid.
- Bubble definition:
  - ex_valid = 0; ex_ctrl = 0; ID_EX_rs1 = ID_EX_rs2 = ex_rd = 0; all XLEN payload = 0.
  - Zero indices guarantee no forwarding match and no regwrite.
- Latency: 1 cycle ID to EX. No combinational path from id_* to ex_* outputs.
- id_valid = 0 captures like a bubble: ctrl is forced to 0 and indices to 0.
- A back-to-back load followed by a dependent instruction gives exactly one bubble. The second cycle has ex_valid = 0, so lu deasserts.
- x0 destination never triggers lu.

Optional Feature:
- Macro: IDEX_WB_BYPASS_EN.
- Defined: on capture, if wb_regwrite & wb_rd != 0 & wb_rd == id_rs1, ex_rs1_data takes wb_data instead of id_rs1_data. rs2 is handled likewise. This covers a register file that is read-first within a cycle.
- Undefined: wb_* ports remain but are ignored, and the register file must be write-first.

Decomposition:
- Package core_pkg holds:
  - XLEN and CTRL_W.
  - Control bit-index localparams CTRL_REGWRITE … CTRL_USES_RS.
  - A BUBBLE_CTRL constant (all zero).
- One natural sub-module: load_use_detect (pure combinational lu equation), reused by the future hazard unit.

Test Plan:
- Plain capture: id_valid = 1, rs1 = 3, rs2 = 4, rd = 5, imm = 0x10, ctrl REGWRITE → next edge ex_* equal the inputs, ex_valid = 1, o_load_use_stall = 0.
- Load-use: EX holds lw x7 (MEMREAD, rd = 7); ID presents add using rs1 = 7 → o_load_use_stall = 1 that cycle; next edge bubble (ex_valid = 0, ID_EX_rs1 = 0); following edge add captured and stall drops.
- Stall precedence: i_stall = 1 for 3 cycles with changing id_* and i_flush = 1 → ex_* unchanged all 3 cycles; the first edge after i_stall drops with flush still high produces a bubble.
- Flush vs load-use: lu condition true and i_flush = 1 → o_load_use_stall = 0, bubble inserted.
- x0 and reset: lw x0 in EX with consumer rs1 = 0 → no stall; rst_n = 0 mid-stream → all outputs 0 at the next edge.
- Bypass (macro defined): wb_regwrite = 1, wb_rd = 9, wb_data = 0xDEAD, id_rs2 = 9, id_rs2_data = 0 → ex_rs2_data = 0xDEAD. With the macro undefined → ex_rs2_data = 0.
